viterbi_frame_ctrl: RTL and testbench
=====================================

Name: viterbi_frame_ctrl

Overview:
Frame sequencer for the Viterbi front-end branch-metric chain (first stage, second stage, steady-state BMU).
- Accepts a stream of received 2-bit symbol pairs over a valid/ready handshake.
- Steers pair 0 to the first stage, pair 1 to the second stage, and every later pair to the steady-state BMU.
- Counts the frame, waits for the pipeline to drain, then issues a one-cycle registered refresh that clears the chain for the next frame.

Parameters:
FRAME_PAIRS, 16, received pairs per frame including tail pairs; legal range 3..2^CNT_W-1
CNT_W, 8, width of the pair index counter
DRAIN_CYCLES, 3, cycles from the last accepted pair to frame_done (covers BMU chain latency)
TIMEOUT, 64, maximum consecutive stall cycles (in_valid low while in_ready high) tolerated mid-frame

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  begin a frame; sampled only in IDLE
abort  in  1  cancel the current frame; any state except IDLE and REFRESH
in_valid  in  1  in_pair is valid
in_pair  in  2  received symbol pair, MSB = first coded bit
in_ready  out  1  controller accepts in_pair this cycle
bit_pair_0  out  2  registered pair for the first stage
bit_pair_1  out  2  registered pair for the second stage
bit_pair_input  out  2  registered pair for the steady-state BMU
ld0  out  1  one-cycle strobe: bit_pair_0 updated
ld1  out  1  one-cycle strobe: bit_pair_1 updated
ldn  out  1  one-cycle strobe: bit_pair_input updated
refresh  out  1  registered one-cycle clear pulse to the whole BMU chain
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse: frame completed normally
pair_idx  out  CNT_W  count of pairs accepted in the current frame
err_timeout  out  1  sticky; set on stall timeout, cleared by the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. Every output is 0: bit_pair_*, strobes, refresh, busy, frame_done, pair_idx, err_timeout, in_ready. The stall counter is 0.
- Transfer: a pair is accepted when in_valid & in_ready. in_ready is a registered function of state; it is high only in LOAD0, LOAD1 and STREAM.
- IDLE: when start=1, go to LOAD0, clear pair_idx, clear err_timeout.
- LOAD0: on transfer, bit_pair_0<=in_pair, ld0=1 on the next cycle, pair_idx=1, go to LOAD1.
- LOAD1: on transfer, bit_pair_1<=in_pair, ld1=1, pair_idx=2, go to STREAM.
- STREAM: each transfer updates bit_pair_input<=in_pair, pulses ldn, increments pair_idx. When the accepted pair makes pair_idx reach FRAME_PAIRS, go to DRAIN.
- Holding: bit_pair_0 and bit_pair_1 hold their values for the whole frame. bit_pair_input holds between transfers.
- DRAIN: in_ready=0. Count DRAIN_CYCLES cycles, then pulse frame_done for one cycle and go to REFRESH.
- REFRESH: refresh=1 for exactly one cycle, then IDLE. bit_pair_* are zeroed in the same cycle.
- Stall: in LOAD0, LOAD1 or STREAM, the stall counter increments each cycle without a transfer and clears on a transfer. When the counter reaches TIMEOUT: set err_timeout, go to REFRESH, no frame_done.
- abort=1 in LOAD0, LOAD1, STREAM or DRAIN: go to REFRESH next cycle, no frame_done. The pair offered in that cycle is not accepted (in_ready forced 0).
- abort has priority over a same-cycle transfer or timeout.
- start outside IDLE is ignored. start and abort together in IDLE: start wins.
- pair_idx never exceeds FRAME_PAIRS. No wrap is possible within the legal range.
- refresh is a registered flop output, never combinational, because downstream stages treat it as a level clear.

Decomposition:
- Shared package viterbi_pkg holds:
  - state enum: IDLE, LOAD0, LOAD1, STREAM, DRAIN, REFRESH
  - pair width constant PAIR_W=2
  - default DRAIN_CYCLES
- One sub-module: vit_stall_timer. It is a loadable up-counter with clear, enable and a terminal flag, reused for both the stall timeout and the DRAIN count.

Test Plan:
- Normal frame, FRAME_PAIRS=4, pairs 11,01,10,00 with in_valid always high -> ld0 with bit_pair_0=11; ld1 with bit_pair_1=01; two ldn strobes with bit_pair_input=10 then 00; frame_done exactly 3 cycles after the last transfer; refresh 1 cycle later; busy falls in the same cycle.
- Bubbled input: in_valid low 5 cycles between pairs 2 and 3 -> in_ready stays high; no strobes during the gap; pair_idx holds at 2; frame completes normally; err_timeout=0.
- Stall timeout, TIMEOUT=8: stop in_valid after pair 1 -> after 8 idle cycles err_timeout=1, refresh pulses once, no frame_done, return to IDLE; the next start clears err_timeout.
- abort during STREAM, asserted together with in_valid -> that pair is not accepted, pair_idx unchanged, refresh next cycle, no frame_done.
- Asynchronous reset asserted mid-DRAIN -> all outputs 0 immediately without a clock edge; after release, start runs a fresh frame from pair_idx=0.
- start pulsed while busy, and start+abort together in IDLE -> the first is ignored; the second begins a frame in LOAD0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi front-end frame sequencer.
// Holds the controller state encoding, the symbol pair width and the default
// drain length covering the BMU chain latency.
package viterbi_pkg;

    localparam int unsigned PAIR_W               = 2;
    localparam int unsigned DEFAULT_DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD0   = 3'd1,
        LOAD1   = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4,
        REFRESH = 3'd5
    } state_e;

    // States in which the controller is willing to accept a pair.
    function automatic logic is_load_state(input state_e s);
        return (s == LOAD0) || (s == LOAD1) || (s == STREAM);
    endfunction

endpackage

// File: rtl/vit_stall_timer.sv
// Loadable up-counter with clear, enable and a terminal-count flag.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clr           zero the count (highest priority)
//   load/load_val load a preset count
//   en            increment by one
//   term_val      terminal value compared against the current count
//   term_c        combinational: current count equals term_val
module vit_stall_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic         term_c
);

    logic [W-1:0] cnt_d, cnt_q;

    // Next count: clear beats load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_c = (cnt_q == term_val);

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi branch-metric chain. Steers pair 0 to the
// first stage, pair 1 to the second stage and later pairs to the steady-state
// BMU, drains the chain after the last pair and then issues a refresh pulse.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, abort        frame control
//   in_valid/in_pair    pair stream, accepted with in_ready
//   bit_pair_*, ld*     registered pairs and their one-cycle update strobes
//   refresh             registered one-cycle clear for the BMU chain
//   busy, frame_done    status; pair_idx counts accepted pairs
//   err_timeout         sticky stall-timeout flag, cleared by the next start
// DRAIN_CYCLES must be at least 2; FRAME_PAIRS must lie in 3..2^CNT_W-1.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned FRAME_PAIRS  = 16,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [PAIR_W-1:0] in_pair,
    output logic              in_ready,
    output logic [PAIR_W-1:0] bit_pair_0,
    output logic [PAIR_W-1:0] bit_pair_1,
    output logic [PAIR_W-1:0] bit_pair_input,
    output logic              ld0,
    output logic              ld1,
    output logic              ldn,
    output logic              refresh,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  pair_idx,
    output logic              err_timeout
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + DRAIN_CYCLES + 1);

    state_e            state_d, state_q;
    logic              in_ready_d, in_ready_q;
    logic [PAIR_W-1:0] bp0_d, bp0_q;
    logic [PAIR_W-1:0] bp1_d, bp1_q;
    logic [PAIR_W-1:0] bpi_d, bpi_q;
    logic              ld0_d, ld0_q;
    logic              ld1_d, ld1_q;
    logic              ldn_d, ldn_q;
    logic              refresh_d, refresh_q;
    logic              busy_d, busy_q;
    logic              frame_done_d, frame_done_q;
    logic [CNT_W-1:0]  pair_idx_d, pair_idx_q;
    logic              err_d, err_q;

    logic              xfer_c;
    logic              last_pair_c;
    logic              tmr_clr, tmr_load, tmr_en;
    logic [TMR_W-1:0]  tmr_term_val;
    logic              tmr_term_c;

    // abort masks acceptance even though the registered in_ready is still high.
    assign xfer_c      = in_valid & in_ready_q & ~abort;
    assign last_pair_c = (pair_idx_q == CNT_W'(FRAME_PAIRS - 1));

    // One timer serves the stall count in the load states and the drain count.
    vit_stall_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (TMR_W'(1)),
        .en       (tmr_en),
        .term_val (tmr_term_val),
        .term_c   (tmr_term_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        bp0_d        = bp0_q;
        bp1_d        = bp1_q;
        bpi_d        = bpi_q;
        pair_idx_d   = pair_idx_q;
        err_d        = err_q;
        ld0_d        = 1'b0;
        ld1_d        = 1'b0;
        ldn_d        = 1'b0;
        frame_done_d = 1'b0;
        tmr_clr      = 1'b0;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        // Stall terminal is TIMEOUT-1 so the TIMEOUT-th idle cycle trips it.
        tmr_term_val = (state_q == DRAIN) ? TMR_W'(DRAIN_CYCLES - 1)
                                          : TMR_W'(TIMEOUT - 1);

        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (start) begin
                    state_d    = LOAD0;
                    pair_idx_d = '0;
                    err_d      = 1'b0;
                end
            end

            LOAD0, LOAD1, STREAM: begin
                if (abort) begin
                    state_d = REFRESH;
                    tmr_clr = 1'b1;
                end else if (xfer_c) begin
                    pair_idx_d = pair_idx_q + CNT_W'(1);
                    tmr_clr    = 1'b1;
                    case (state_q)
                        LOAD0: begin
                            bp0_d   = in_pair;
                            ld0_d   = 1'b1;
                            state_d = LOAD1;
                        end
                        LOAD1: begin
                            bp1_d   = in_pair;
                            ld1_d   = 1'b1;
                            state_d = STREAM;
                        end
                        default: begin
                            bpi_d = in_pair;
                            ldn_d = 1'b1;
                            if (last_pair_c) begin
                                // Drain count starts at 1: the first DRAIN cycle.
                                state_d  = DRAIN;
                                tmr_clr  = 1'b0;
                                tmr_load = 1'b1;
                            end
                        end
                    endcase
                end else if (tmr_term_c) begin
                    err_d   = 1'b1;
                    state_d = REFRESH;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            DRAIN: begin
                if (abort) begin
                    state_d = REFRESH;
                end else if (tmr_term_c) begin
                    frame_done_d = 1'b1;
                    state_d      = REFRESH;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            REFRESH: begin
                state_d = IDLE;
                bp0_d   = '0;
                bp1_d   = '0;
                bpi_d   = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = is_load_state(state_d);
        busy_d     = (state_d != IDLE);
        // Clear pulse follows the REFRESH state, aligned with the zeroed pairs.
        refresh_d  = (state_q == REFRESH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            bp0_q        <= '0;
            bp1_q        <= '0;
            bpi_q        <= '0;
            ld0_q        <= 1'b0;
            ld1_q        <= 1'b0;
            ldn_q        <= 1'b0;
            refresh_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pair_idx_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            bp0_q        <= bp0_d;
            bp1_q        <= bp1_d;
            bpi_q        <= bpi_d;
            ld0_q        <= ld0_d;
            ld1_q        <= ld1_d;
            ldn_q        <= ldn_d;
            refresh_q    <= refresh_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pair_idx_q   <= pair_idx_d;
            err_q        <= err_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign bit_pair_0     = bp0_q;
    assign bit_pair_1     = bp1_q;
    assign bit_pair_input = bpi_q;
    assign ld0            = ld0_q;
    assign ld1            = ld1_q;
    assign ldn            = ldn_q;
    assign refresh        = refresh_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign pair_idx       = pair_idx_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: stimulus pushes expected strobe
// events (ld0/ld1/ldn/frame_done/refresh) with the pair snapshot, pair_idx,
// err_timeout, busy and the cycle gap to the previous event; a monitor pops
// and compares whenever a strobe appears.
module tb_viterbi_frame_ctrl;

    localparam int unsigned FP = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned DC = 3;
    localparam int unsigned TO = 8;

    localparam int K_LD0  = 0;
    localparam int K_LD1  = 1;
    localparam int K_LDN  = 2;
    localparam int K_DONE = 3;
    localparam int K_REF  = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    in_pair  = 2'b00;
    logic          in_ready;
    logic [1:0]    bit_pair_0, bit_pair_1, bit_pair_input;
    logic          ld0, ld1, ldn, refresh, busy, frame_done, err_timeout;
    logic [CW-1:0] pair_idx;
    logic [21:0]   outs;

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(
        .FRAME_PAIRS  (FP),
        .CNT_W        (CW),
        .DRAIN_CYCLES (DC),
        .TIMEOUT      (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_pair        (in_pair),
        .in_ready       (in_ready),
        .bit_pair_0     (bit_pair_0),
        .bit_pair_1     (bit_pair_1),
        .bit_pair_input (bit_pair_input),
        .ld0            (ld0),
        .ld1            (ld1),
        .ldn            (ldn),
        .refresh        (refresh),
        .busy           (busy),
        .frame_done     (frame_done),
        .pair_idx       (pair_idx),
        .err_timeout    (err_timeout)
    );

    assign outs = {in_ready, bit_pair_0, bit_pair_1, bit_pair_input, ld0, ld1, ldn,
                   refresh, busy, frame_done, pair_idx, err_timeout};

    typedef struct {
        string      tag;
        int         kind;
        logic [5:0] bp;
        int         idx;
        logic       err;
        logic       busy;
        int         gap;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_ev_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input string tag, input int kind, input logic [5:0] bp,
                             input int idx, input logic err, input logic bsy, input int gap);
        ev_t e;
        e.tag = tag; e.kind = kind; e.bp = bp; e.idx = idx;
        e.err = err; e.busy = bsy; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t        e;
        int         gap;
        logic [5:0] bp;
        gap = cyc - last_ev_cyc;
        last_ev_cyc = cyc;
        bp = {bit_pair_0, bit_pair_1, bit_pair_input};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d at cycle %0d, want no event", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.bp != bp || e.idx != int'(pair_idx) || e.err != err_timeout ||
            e.busy != busy || (e.gap >= 0 && e.gap != gap)) begin
            n_err++;
            $display("FAIL %s: got kind=%0d bp=%h idx=%0d err=%0b busy=%0b gap=%0d, want kind=%0d bp=%h idx=%0d err=%0b busy=%0b gap=%0d",
                     e.tag, kind, bp, pair_idx, err_timeout, busy, gap,
                     e.kind, e.bp, e.idx, e.err, e.busy, e.gap);
        end
    endtask

    // Monitor: one event per asserted strobe.
    always @(negedge clk) begin
        if (rst) begin
            if (ld0)        observe(K_LD0);
            if (ld1)        observe(K_LD1);
            if (ldn)        observe(K_LDN);
            if (frame_done) observe(K_DONE);
            if (refresh)    observe(K_REF);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] p);
        int n = 0;
        in_valid = 1'b1;
        in_pair  = p;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_ready: in_ready stayed %0b for pair %b, want 1", in_ready, p);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, want 0", busy, n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal end");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(outs), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_release", 32'({busy, in_ready}), 32'h0);

        // Normal frame: 11,01,10,00
        start_frame();
        chk("load0_ready", 32'(in_ready), 32'h1);
        expect_ev("t1_ld0",  K_LD0,  6'b11_00_00, 1, 1'b0, 1'b1, -1);
        expect_ev("t1_ld1",  K_LD1,  6'b11_01_00, 2, 1'b0, 1'b1, 1);
        expect_ev("t1_ldn0", K_LDN,  6'b11_01_10, 3, 1'b0, 1'b1, 1);
        expect_ev("t1_ldn1", K_LDN,  6'b11_01_00, 4, 1'b0, 1'b1, 1);
        expect_ev("t1_done", K_DONE, 6'b11_01_00, 4, 1'b0, 1'b1, 2);
        expect_ev("t1_ref",  K_REF,  6'b00_00_00, 4, 1'b0, 1'b0, 1);
        send(2'b11); send(2'b01); send(2'b10); send(2'b00);
        wait_idle();

        // Bubbled input: 5 idle cycles between pairs 2 and 3
        start_frame();
        expect_ev("t2_ld0",  K_LD0,  6'b10_00_00, 1, 1'b0, 1'b1, -1);
        expect_ev("t2_ld1",  K_LD1,  6'b10_11_00, 2, 1'b0, 1'b1, 1);
        expect_ev("t2_ldn0", K_LDN,  6'b10_11_01, 3, 1'b0, 1'b1, 6);
        expect_ev("t2_ldn1", K_LDN,  6'b10_11_10, 4, 1'b0, 1'b1, 1);
        expect_ev("t2_done", K_DONE, 6'b10_11_10, 4, 1'b0, 1'b1, 2);
        expect_ev("t2_ref",  K_REF,  6'b00_00_00, 4, 1'b0, 1'b0, 1);
        send(2'b10); send(2'b11);
        repeat (5) @(negedge clk);
        chk("gap_in_ready", 32'(in_ready), 32'h1);
        chk("gap_pair_idx", 32'(pair_idx), 32'd2);
        send(2'b01); send(2'b10);
        wait_idle();
        chk("bubble_no_err", 32'(err_timeout), 32'h0);

        // Stall timeout after pair 0
        start_frame();
        expect_ev("t3_ld0", K_LD0, 6'b01_00_00, 1, 1'b0, 1'b1, -1);
        expect_ev("t3_ref", K_REF, 6'b00_00_00, 1, 1'b1, 1'b0, 9);
        send(2'b01);
        repeat (8) @(negedge clk);
        chk("timeout_err_set", 32'({err_timeout, busy}), 32'h3);
        wait_idle();
        chk("timeout_err_sticky", 32'(err_timeout), 32'h1);
        start_frame();
        chk("start_clears_err", 32'({err_timeout, busy}), 32'h1);

        // Abort in STREAM together with a valid pair
        expect_ev("t4_ld0", K_LD0, 6'b01_00_00, 1, 1'b0, 1'b1, -1);
        expect_ev("t4_ld1", K_LD1, 6'b01_10_00, 2, 1'b0, 1'b1, 1);
        expect_ev("t4_ref", K_REF, 6'b00_00_00, 2, 1'b0, 1'b0, 2);
        send(2'b01); send(2'b10);
        abort = 1'b1; in_valid = 1'b1; in_pair = 2'b11;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_idx_held", 32'(pair_idx), 32'd2);
        chk("abort_no_ready", 32'(in_ready), 32'h0);
        wait_idle();

        // Asynchronous reset in DRAIN
        start_frame();
        expect_ev("t5_ld0",  K_LD0, 6'b10_00_00, 1, 1'b0, 1'b1, -1);
        expect_ev("t5_ld1",  K_LD1, 6'b10_01_00, 2, 1'b0, 1'b1, 1);
        expect_ev("t5_ldn0", K_LDN, 6'b10_01_11, 3, 1'b0, 1'b1, 1);
        expect_ev("t5_ldn1", K_LDN, 6'b10_01_01, 4, 1'b0, 1'b1, 1);
        send(2'b10); send(2'b01); send(2'b11); send(2'b01);
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", 32'(outs), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 32'({busy, pair_idx}), 32'h0);

        // Fresh frame, with start pulsed while busy
        start_frame();
        chk("fresh_idx0", 32'({busy, pair_idx}), 32'h100);
        expect_ev("t6_ld0",  K_LD0,  6'b11_00_00, 1, 1'b0, 1'b1, -1);
        expect_ev("t6_ld1",  K_LD1,  6'b11_10_00, 2, 1'b0, 1'b1, 1);
        expect_ev("t6_ldn0", K_LDN,  6'b11_10_01, 3, 1'b0, 1'b1, 1);
        expect_ev("t6_ldn1", K_LDN,  6'b11_10_00, 4, 1'b0, 1'b1, 1);
        expect_ev("t6_done", K_DONE, 6'b11_10_00, 4, 1'b0, 1'b1, 2);
        expect_ev("t6_ref",  K_REF,  6'b00_00_00, 4, 1'b0, 1'b0, 1);
        send(2'b11); send(2'b10);
        start = 1'b1;
        send(2'b01);
        start = 1'b0;
        send(2'b00);
        wait_idle();
        chk("busy_start_ignored", 32'(busy), 32'h0);

        // start and abort together in IDLE: start wins, then abort from LOAD0
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_beats_abort", 32'({busy, in_ready}), 32'h3);
        expect_ev("t7_ref", K_REF, 6'b00_00_00, 0, 1'b0, 1'b0, -1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle();

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
